mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Load/store adapter between the EX/MEM pipeline register and the data memory. The data memory only accepts dword-based accesses: combinational read, posedge write, funct3 011. This block converts every RV64 load/store size (b/h/w/d, signed and unsigned) at any byte address into those accesses. In-dword stores use read-modify-write. Accesses that cross a dword boundary are split over two cycles by a small FSM, which stalls the pipeline.

Parameters:
DMEM_BYTES, 64, data memory size in bytes; accesses reaching past it are rejected.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  memory request present this cycle
req_read  in  1  load request (MemRead)
req_write  in  1  store request (MemWrite)
req_addr  in  64  byte address
req_wdata  in  64  store data, LSB-aligned
req_funct3  in  3  RV64 size/sign code
stall  out  1  hold upstream request and freeze pipeline
ld_data  out  64  extended load result, valid when ld_valid
ld_valid  out  1  load completes this cycle
access_err  out  1  illegal/out-of-range/trapped access this cycle
mem_addr  out  64  dword-aligned address to data memory
mem_wdata  out  64  merged dword write data
mem_read  out  1  data memory read enable
mem_write  out  1  data memory write enable
mem_funct3  out  3  always 011 when mem_read or mem_write is high, else 000
mem_rdata  in  64  combinational dword read data

Behaviour:
- Size is 1/2/4/8 bytes for funct3[1:0] = 00/01/10/11. Loads with funct3[2]=1 are zero-extended, otherwise sign-extended. off = req_addr[2:0], base = req_addr & ~7.
- Illegal cases assert access_err for one cycle with no memory access, ld_data=0, and stall=0:
  - both req_read and req_write high;
  - load funct3=111;
  - store funct3[2]=1;
  - req_addr+size > DMEM_BYTES.
- Single access (off+size <= 8), FSM stays in IDLE, zero added latency:
  - mem_addr=base, mem_read=1.
  - Load: ld_data = extracted bytes off..off+size-1 of mem_rdata, extended; ld_valid=1.
  - Store: mem_write=1, mem_wdata = mem_rdata with bytes off..off+size-1 replaced by req_wdata low bytes. Aligned sd may drive req_wdata directly.
- Split access (off+size > 8):
  - IDLE cycle:
    - mem_addr=base, mem_read=1, stall=1.
    - Load: latch mem_rdata bytes off..7 into lo_buf.
    - Store: write mem_rdata merged with req_wdata bytes 0..7-off at lanes off..7.
    - Next state SECOND.
  - SECOND cycle:
    - mem_addr=base+8, mem_read=1, stall=0.
    - Load: ld_data = {mem_rdata bytes 0..n-1, lo_buf}, extended, where n = off+size-8; ld_valid=1.
    - Store: mem_write=1; lanes 0..n-1 take req_wdata bytes 8-off onward.
    - Next state IDLE.
- Upstream holds req_* stable while stall=1. If req_valid=0 in SECOND, the access aborts: no memory access, ld_valid=0, next state IDLE. A split store abort leaves the low half written.
- Idle cycles (req_valid=0 in IDLE): mem_read, mem_write, ld_valid, access_err and stall are 0; ld_data=0.
- Reset (async, any state):
  - FSM=IDLE, lo_buf=0.
  - While reset_n=0, all outputs are 0.
  - Reset during SECOND discards the access; a partial store remains.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: any split access is not performed. access_err=1 and stall=0 for one cycle, no mem_write, ld_data=0. The FSM never leaves IDLE.
- Undefined: split accesses are executed as described in Behaviour.

Test Plan:
- Bench preloads byte0=0xEB; lb at 0 / lbu at 0 -> ld_data=0xFFFF_FFFF_FFFF_FFEB / 0x0000_0000_0000_00EB, ld_valid=1, stall=0, mem_addr=0, mem_funct3=011.
- sb wdata=0xAA at addr 5 -> same cycle mem_write=1, mem_addr=0, mem_wdata = prior dword with byte5=0xAA, all other bytes unchanged; stall=0.
- lw at addr 6 with bytes 6..9 = 0x11,0x22,0x33,0x84 -> cycle1: stall=1, mem_addr=0; cycle2: stall=0, mem_addr=8, ld_data=0xFFFF_FFFF_8433_2211.
- sd 0x0807_0605_0403_0201 at addr 4 -> cycle1: write addr 0 with bytes4..7=01..04; cycle2: write addr 8 with bytes0..3=05..08; memory reads back the value at addr 4.
- lw at addr 6 with reset_n pulsed low in SECOND -> no access to addr 8, ld_valid never 1, FSM IDLE; repeat with req_valid dropped in SECOND -> same result.
- ld at addr 60 (DMEM_BYTES=64) -> access_err=1, mem_read=0, mem_write=0, ld_data=0; with MISALIGN_TRAP_EN, lw at addr 6 -> access_err=1, stall=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV64 load/store adapter onto a dword-only, combinational-read data memory.
// Define MISALIGN_TRAP_EN to trap dword-crossing accesses instead of splitting them over two cycles.
module mem_access_unit #(
  parameter int unsigned DMEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        stall,
  output logic [63:0] ld_data,
  output logic        ld_valid,
  output logic        access_err,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  input  logic [63:0] mem_rdata
);

  localparam logic [2:0] DWORD_F3 = 3'b011;

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [63:0] lo_buf, lo_buf_nxt;

  logic [2:0]   off;
  logic [3:0]   size;
  logic [3:0]   end_pos;
  logic         split;
  logic [15:0]  lane_mask;
  logic [127:0] wdata_sh;
  logic [63:0]  base;
  logic         range_err;
  logic         illegal;
  logic         active;
  logic [2:0]   hi_shift;

  // Byte-lane replace: lanes with mask set take new data, others keep memory contents
  function automatic logic [63:0] merge(input logic [63:0] old_d, input logic [63:0] new_d,
                                        input logic [7:0] mask);
    logic [63:0] r;
    r = old_d;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) r[8*i +: 8] = new_d[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] raw, input logic [2:0] f3);
    logic [63:0] r;
    r = raw;
    case (f3[1:0])
      2'b00:   r = f3[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'b01:   r = f3[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'b10:   r = f3[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  // Request decode shared by both FSM states (request is held stable while stalled)
  always_comb begin
    off       = req_addr[2:0];
    size      = 4'd1 << req_funct3[1:0];
    end_pos   = {1'b0, off} + size;
    split     = end_pos > 4'd8;
    lane_mask = ((16'd1 << size) - 16'd1) << off;
    wdata_sh  = {64'd0, req_wdata} << {off, 3'b000};
    base      = {req_addr[63:3], 3'b000};
    hi_shift  = 3'(4'd8 - {1'b0, off});
    range_err = ({1'b0, req_addr} + 65'(size)) > 65'(DMEM_BYTES);
    active    = req_valid & (req_read | req_write);
    illegal   = (req_read & req_write) | (req_read & (req_funct3 == 3'b111)) |
                (req_write & req_funct3[2]) | range_err;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      lo_buf <= '0;
    end else begin
      state  <= state_nxt;
      lo_buf <= lo_buf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    lo_buf_nxt = lo_buf;
    stall      = 1'b0;
    ld_data    = '0;
    ld_valid   = 1'b0;
    access_err = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = '0;

    case (state)
      IDLE: begin
        if (active) begin
          if (illegal) begin
            access_err = 1'b1;
          end else if (split) begin
`ifdef MISALIGN_TRAP_EN
            access_err = 1'b1;
`else
            mem_addr = base;
            mem_read = 1'b1;
            stall    = 1'b1;
            if (req_write) begin
              mem_write = 1'b1;
              mem_wdata = merge(mem_rdata, wdata_sh[63:0], lane_mask[7:0]);
            end else begin
              lo_buf_nxt = mem_rdata >> {off, 3'b000};
            end
            state_nxt = SECOND;
`endif
          end else begin
            mem_addr = base;
            mem_read = 1'b1;
            if (req_write) begin
              mem_write = 1'b1;
              mem_wdata = merge(mem_rdata, wdata_sh[63:0], lane_mask[7:0]);
            end else begin
              ld_data  = extend(mem_rdata >> {off, 3'b000}, req_funct3);
              ld_valid = 1'b1;
            end
          end
        end
      end

      SECOND: begin
        // Dropping req_valid here abandons the upper half; the FSM always returns to IDLE
        state_nxt = IDLE;
        if (active) begin
          mem_addr = base + 64'd8;
          mem_read = 1'b1;
          if (req_write) begin
            mem_write = 1'b1;
            mem_wdata = merge(mem_rdata, wdata_sh[127:64], lane_mask[15:8]);
          end else begin
            ld_data  = extend(lo_buf | (mem_rdata << {hi_shift, 3'b000}), req_funct3);
            ld_valid = 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (mem_read || mem_write) mem_funct3 = DWORD_F3;

    if (!reset_n) begin
      stall      = 1'b0;
      ld_data    = '0;
      ld_valid   = 1'b0;
      access_err = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_funct3 = '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed plus random loads/stores against a byte-array reference memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_read, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        stall, ld_valid, access_err, mem_read, mem_write;
  logic [63:0] ld_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;
  logic        mem_clr;

  logic [63:0] dmem [8];
  logic [7:0]  ref_mem [64];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] got;

  always #5 clk = ~clk;

  mem_access_unit #(.DMEM_BYTES(64)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid), .access_err(access_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  // Data memory: combinational dword read, posedge dword write
  assign mem_rdata = (mem_read && mem_addr < 64'd64) ? dmem[mem_addr[5:3]] : 64'd0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) dmem[i] <= 64'd0;
    end else if (mem_write && mem_funct3 == 3'b011 && mem_addr < 64'd64) begin
      dmem[mem_addr[5:3]] <= mem_wdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference load: gather bytes from the reference memory, then extend by size/sign
  function automatic logic [63:0] load_model(input int a, input logic [2:0] f3);
    int unsigned sz;
    logic [63:0] v;
    sz = 1 << f3[1:0];
    v = 64'd0;
    for (int i = 0; i < 8; i++) if (i < sz) v[8*i +: 8] = ref_mem[a + i];
    if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
    return v;
  endfunction

  task automatic do_access(input logic rd, input logic wr, input logic [63:0] a,
                           input logic [63:0] wd, input logic [2:0] f3, output logic [63:0] obs);
    int unsigned sz, off;
    int ai, bi;
    logic err, split;
    logic [63:0] exp_ld, lo_w, hi_w, base;
    logic [7:0] nm [64];
    sz    = 1 << f3[1:0];
    off   = int'(a[2:0]);
    split = (off + sz) > 8;
    err   = (rd && wr) || (rd && f3 == 3'b111) || (wr && f3[2]) || (a + 64'(sz) > 64'd64);
`ifdef MISALIGN_TRAP_EN
    if (split) err = 1'b1;
`endif
    ai = int'(a[15:0]);
    base = a & ~64'd7;
    bi = int'(base[15:0]);
    exp_ld = 64'd0;
    lo_w = 64'd0;
    hi_w = 64'd0;
    nm = ref_mem;
    if (!err) begin
      if (rd) exp_ld = load_model(ai, f3);
      if (wr) for (int i = 0; i < 8; i++) if (i < sz) nm[ai + i] = wd[8*i +: 8];
      for (int i = 0; i < 8; i++) lo_w[8*i +: 8] = nm[bi + i];
      if (split) for (int i = 0; i < 8; i++) hi_w[8*i +: 8] = nm[bi + 8 + i];
    end

    @(negedge clk);
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_addr = a; req_wdata = wd; req_funct3 = f3;
    #1;
    if (err) begin
      chk("err_flag", 64'(access_err), 64'd1);
      chk("err_rd", 64'(mem_read), 64'd0);
      chk("err_wr", 64'(mem_write), 64'd0);
      chk("err_ld", ld_data, 64'd0);
      chk("err_stall", 64'(stall), 64'd0);
      chk("err_ldv", 64'(ld_valid), 64'd0);
    end else if (split) begin
      chk("s1_stall", 64'(stall), 64'd1);
      chk("s1_addr", mem_addr, base);
      chk("s1_rd", 64'(mem_read), 64'd1);
      chk("s1_wr", 64'(mem_write), 64'(wr));
      chk("s1_f3", 64'(mem_funct3), 64'd3);
      chk("s1_ldv", 64'(ld_valid), 64'd0);
      if (wr) chk("s1_wdata", mem_wdata, lo_w);
      @(negedge clk); #1;
      chk("s2_stall", 64'(stall), 64'd0);
      chk("s2_addr", mem_addr, base + 64'd8);
      chk("s2_rd", 64'(mem_read), 64'd1);
      chk("s2_wr", 64'(mem_write), 64'(wr));
      chk("s2_ldv", 64'(ld_valid), 64'(rd));
      if (wr) chk("s2_wdata", mem_wdata, hi_w);
      if (rd) chk("s2_ld", ld_data, exp_ld);
    end else begin
      chk("s_stall", 64'(stall), 64'd0);
      chk("s_addr", mem_addr, base);
      chk("s_rd", 64'(mem_read), 64'd1);
      chk("s_wr", 64'(mem_write), 64'(wr));
      chk("s_f3", 64'(mem_funct3), 64'd3);
      chk("s_ldv", 64'(ld_valid), 64'(rd));
      chk("s_err", 64'(access_err), 64'd0);
      if (wr) chk("s_wdata", mem_wdata, lo_w);
      if (rd) chk("s_ld", ld_data, exp_ld);
    end
    obs = ld_data;
    if (!err) ref_mem = nm;
  endtask

  task automatic idle_chk();
    @(negedge clk);
    req_valid = 1'b0; req_read = 1'($urandom); req_write = 1'($urandom);
    req_addr = 64'($urandom_range(0, 63)); req_funct3 = 3'($urandom);
    #1;
    chk("idle_rd", 64'(mem_read), 64'd0);
    chk("idle_wr", 64'(mem_write), 64'd0);
    chk("idle_stall", 64'(stall), 64'd0);
    chk("idle_ldv", 64'(ld_valid), 64'd0);
    chk("idle_err", 64'(access_err), 64'd0);
    chk("idle_ld", ld_data, 64'd0);
  endtask

  task automatic check_mem();
    logic [63:0] w;
    idle_chk();
    for (int d = 0; d < 8; d++) begin
      for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_mem[8*d + i];
      chk($sformatf("mem%0d", d), dmem[d], w);
    end
  endtask

  initial begin
    logic rd, wr;
    logic [2:0] f3;
    int k;
    logic [63:0] wd;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'd0;
    reset_n = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
    req_addr = 64'd0; req_wdata = 64'd0; req_funct3 = 3'b011;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd", 64'(mem_read), 64'd0);
    chk("rst_wr", 64'(mem_write), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_ldv", 64'(ld_valid), 64'd0);
    chk("rst_err", 64'(access_err), 64'd0);
    chk("rst_ld", ld_data, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_f3", 64'(mem_funct3), 64'd0);
    @(negedge clk);
    mem_clr = 1'b0; reset_n = 1'b1; req_valid = 1'b0;
    idle_chk();

    do_access(1'b0, 1'b1, 64'd0, 64'hEB, 3'b000, got);
    do_access(1'b1, 1'b0, 64'd0, 64'd0, 3'b000, got);
    chk("lb0", got, 64'hFFFF_FFFF_FFFF_FFEB);
    do_access(1'b1, 1'b0, 64'd0, 64'd0, 3'b100, got);
    chk("lbu0", got, 64'h0000_0000_0000_00EB);
    do_access(1'b0, 1'b1, 64'd5, 64'h1234_56AA, 3'b000, got);
    do_access(0, 1, 64'd6, 64'h2211, 3'b001, got);
    do_access(0, 1, 64'd8, 64'h8433, 3'b001, got);
    check_mem();
    do_access(1, 0, 64'd6, 64'd0, 3'b010, got);
`ifndef MISALIGN_TRAP_EN
    chk("lw6", got, 64'hFFFF_FFFF_8433_2211);
    do_access(0, 1, 64'd4, 64'h0807_0605_0403_0201, 3'b011, got);
    check_mem();
    do_access(1, 0, 64'd4, 64'd0, 3'b011, got);
    chk("ld4", got, 64'h0807_0605_0403_0201);

    // Reset during the second half of a split load
    @(negedge clk);
    req_valid = 1; req_read = 1; req_write = 0; req_addr = 64'd6; req_funct3 = 3'b010;
    #1 chk("rs_stall", 64'(stall), 64'd1);
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("rs_rd", 64'(mem_read), 64'd0);
    chk("rs_ldv", 64'(ld_valid), 64'd0);
    chk("rs_addr", mem_addr, 64'd0);
    @(negedge clk); reset_n = 1'b1; req_valid = 1'b0;
    do_access(1, 0, 64'd6, 64'd0, 3'b010, got);

    // Request withdrawn during the second half of a split load
    @(negedge clk);
    req_valid = 1; req_read = 1; req_write = 0; req_addr = 64'd6; req_funct3 = 3'b010;
    #1 chk("ab_stall", 64'(stall), 64'd1);
    @(negedge clk); req_valid = 1'b0;
    #1;
    chk("ab_rd", 64'(mem_read), 64'd0);
    chk("ab_ldv", 64'(ld_valid), 64'd0);
    chk("ab_stall0", 64'(stall), 64'd0);
    do_access(1, 0, 64'd6, 64'd0, 3'b010, got);

    // Withdrawn split store keeps only its low half
    @(negedge clk);
    req_valid = 1; req_read = 0; req_write = 1; req_addr = 64'd12;
    req_wdata = 64'hA1B2_C3D4_E5F6_0718; req_funct3 = 3'b011;
    #1 chk("abs_wr1", 64'(mem_write), 64'd1);
    @(negedge clk); req_valid = 1'b0;
    #1 chk("abs_wr2", 64'(mem_write), 64'd0);
    for (int i = 0; i < 4; i++) ref_mem[12 + i] = req_wdata[8*i +: 8];
    check_mem();
`else
    chk("lw6_trap", got, 64'd0);
    do_access(0, 1, 64'd4, 64'h0807_0605_0403_0201, 3'b011, got);
    check_mem();
`endif

    // Boundary and illegal cases
    do_access(1, 0, 64'd60, 64'd0, 3'b011, got);
    do_access(1, 0, 64'd56, 64'd0, 3'b011, got);
    do_access(1, 0, 64'd63, 64'd0, 3'b000, got);
    do_access(1, 0, 64'd63, 64'd0, 3'b001, got);
    do_access(1, 0, 64'd4, 64'd0, 3'b110, got);
    do_access(1, 0, 64'd7, 64'd0, 3'b101, got);
    do_access(1, 0, 64'd0, 64'd0, 3'b111, got);
    do_access(0, 1, 64'd0, 64'hFF, 3'b100, got);
    do_access(1, 1, 64'd8, 64'hFF, 3'b000, got);
    check_mem();

    for (int it = 0; it < 300; it++) begin
      k = int'($urandom_range(0, 19));
      rd = (k == 0) || (k < 10);
      wr = (k == 0) || (k >= 10);
      f3 = 3'($urandom);
      if (wr && !rd && $urandom_range(0, 9) != 0) f3[2] = 1'b0;
      wd = {$urandom, $urandom};
      do_access(rd, wr, 64'($urandom_range(0, 66)), wd, f3, got);
      if (it % 25 == 24) check_mem();
    end
    check_mem();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
